// File: rtl/code_lock_ctrl.sv
// Two-button code lock: synchronizes buttons A/B into symbols, collects CODE_LEN
// of them, compares against a loadable code and sequences open / retry / lockout.
module code_lock_ctrl #(
    parameter int         CODE_LEN     = 4,
    parameter logic [7:0] DEFAULT_CODE = 8'b0000_1011,
    parameter int         MAX_FAIL     = 3,
    parameter int         OPEN_CYCLES  = 500,
    parameter int         LOCK_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       a,
    input  logic       b,
    input  logic [7:0] code_in,
    input  logic       code_load,
    output logic       unlock,
    output logic       alarm,
    output logic [2:0] state,
    output logic [1:0] fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    localparam logic [7:0]  CODE_MASK = 8'((9'd1 << CODE_LEN) - 9'd1);
    localparam logic [3:0]  LEN_LAST  = 4'(CODE_LEN);
    localparam logic [2:0]  FAIL_LIM  = 3'(MAX_FAIL);
    localparam logic [15:0] OPEN_LAST = 16'(OPEN_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

    logic        a_p0, a_p1, a_p2;
    logic        b_p0, b_p1, b_p2;
    logic        sym_p3, sym_vld_p3;
    logic [1:0]  arm_q;
    logic        rise_a, rise_b;

    state_t      state_q, state_d;
    logic [7:0]  entry_q, entry_d;
    logic [7:0]  code_q, code_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tmr_q, tmr_d;
    logic [1:0]  fail_q, fail_d;
    logic        unlock_q, alarm_q;

    assign rise_a = a_p1 & ~a_p2;
    assign rise_b = b_p1 & ~b_p2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_p0       <= 1'b0;
            a_p1       <= 1'b0;
            a_p2       <= 1'b0;
            b_p0       <= 1'b0;
            b_p1       <= 1'b0;
            b_p2       <= 1'b0;
            sym_p3     <= 1'b0;
            sym_vld_p3 <= 1'b0;
            arm_q      <= 2'd0;
            state_q    <= S_IDLE;
            entry_q    <= 8'd0;
            code_q     <= DEFAULT_CODE;
            cnt_q      <= 4'd0;
            tmr_q      <= 16'd0;
            fail_q     <= 2'd0;
            unlock_q   <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            // p0/p1: two-flop synchronizer, p2: delay for rising-edge detect
            a_p0       <= a;
            a_p1       <= a_p0;
            a_p2       <= a_p1;
            b_p0       <= b;
            b_p1       <= b_p0;
            b_p2       <= b_p1;
            // p3: symbol pulse; held off until the pipeline holds only post-reset
            // samples so a button already down at reset release is not a press
            if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
            sym_vld_p3 <= (arm_q == 2'd3) & (rise_a ^ rise_b);
            sym_p3     <= rise_a;
            state_q    <= state_d;
            entry_q    <= entry_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            fail_q     <= fail_d;
            unlock_q   <= (state_d == S_OPEN);
            alarm_q    <= (state_d == S_LOCKOUT);
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE: begin
                if (code_load) code_d = code_in;
                if (sym_vld_p3) begin
                    entry_d = {7'd0, sym_p3};
                    cnt_d   = 4'd1;
                    state_d = (LEN_LAST == 4'd1) ? S_CHECK : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (sym_vld_p3) begin
                    entry_d = {entry_q[6:0], sym_p3};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == LEN_LAST) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                entry_d = 8'd0;
                cnt_d   = 4'd0;
                if (((entry_q ^ code_q) & CODE_MASK) == 8'd0) begin
                    state_d = S_OPEN;
                    tmr_d   = 16'd0;
                    fail_d  = 2'd0;
                end else if ({1'b0, fail_q} + 3'd1 == FAIL_LIM) begin
                    state_d = S_LOCKOUT;
                    tmr_d   = 16'd0;
                    fail_d  = fail_q + 2'd1;
                end else begin
                    state_d = S_IDLE;
                    fail_d  = fail_q + 2'd1;
                end
            end
            S_OPEN: begin
                if (tmr_q == OPEN_LAST) state_d = S_IDLE;
                else                    tmr_d   = tmr_q + 16'd1;
            end
            S_LOCKOUT: begin
                if (tmr_q == LOCK_LAST) begin
                    state_d = S_IDLE;
                    fail_d  = 2'd0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                entry_d = 8'd0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign unlock   = unlock_q;
    assign alarm    = alarm_q;
    assign state    = state_q;
    assign fail_cnt = fail_q;

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Two-button code-lock controller. It synchronizes the asynchronous push-button inputs `a` and `b` and turns each clean press into a code symbol. It collects CODE_LEN symbols and compares them against a loadable code register. It then sequences an unlock window, a failed-attempt count and an alarm lockout. It sits above the button sequence-detection logic on the board and owns the lock-side decisions: open, retry, lock out.

## Interface
- CODE_LEN, 4: symbols per attempt, 1..8.
- DEFAULT_CODE, 8'b0000_1011: code register value after reset; low CODE_LEN bits used.
- MAX_FAIL, 3: consecutive mismatches that trigger lockout, 1..3.
- OPEN_CYCLES, 500: clock cycles `unlock` stays high, 1..65535.
- LOCK_CYCLES, 1000: clock cycles `alarm` stays high, 1..65535.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- a  in  1  asynchronous button A; a press is symbol 1.
- b  in  1  asynchronous button B; a press is symbol 0.
- code_in  in  8  new code value; bit CODE_LEN-1 is the first symbol.
- code_load  in  1  synchronous load strobe for `code_in`.
- unlock  out  1  high in OPEN.
- alarm  out  1  high in LOCKOUT.
- state  out  3  current FSM state, for debug and LEDs.
- fail_cnt  out  2  consecutive failed attempts.

## Operation
- Input conditioning:
  - `a` and `b` each pass through a 2-FF synchronizer, then a 1-FF delay for rising-edge detection.
  - Symbol valid = exactly one of edge_a / edge_b high in a cycle.
  - Simultaneous edges on both buttons are discarded; they produce no symbol and are not counted.
- FSM states and transitions:
  - IDLE=0: symbol → ENTRY. The symbol is shifted in and sym_cnt=1. If CODE_LEN=1, go straight to CHECK.
  - ENTRY=1: each symbol is shifted into the entry register at the LSB end (shift left) and sym_cnt increments. The symbol that makes sym_cnt==CODE_LEN → CHECK.
  - CHECK=2: lasts exactly 1 cycle; compares entry[CODE_LEN-1:0] with code_reg[CODE_LEN-1:0].
    - Match → OPEN, fail_cnt←0.
    - Mismatch with fail_cnt+1 == MAX_FAIL → LOCKOUT.
    - Any other mismatch → IDLE, fail_cnt←fail_cnt+1.
  - OPEN=3: timer counts OPEN_CYCLES, then → IDLE.
  - LOCKOUT=4: timer counts LOCK_CYCLES, then → IDLE, fail_cnt←0.
  - Unused encodings 5..7 → IDLE on the next edge.
- Symbols arriving in CHECK, OPEN or LOCKOUT are discarded; they are never buffered.
- Code load: `code_load` high in IDLE loads code_reg←code_in on that edge. It is ignored in every other state.
- The entry register and sym_cnt clear on every entry to IDLE.
- The timer is 16 bits, cleared on entry to OPEN and to LOCKOUT.

## Timing
- Reset (asynchronous assert, synchronous effect of release):
  - state=IDLE, unlock=0, alarm=0, fail_cnt=0.
  - sym_cnt=0, entry=0, timer=0, code_reg=DEFAULT_CODE.
  - All synchronizer flops = 0.
- Symbol latency: a level change on `a`/`b` held across edge k is seen as an edge pulse in the cycle after edge k+2.
  - A button already high when reset releases produces no symbol.
- The final symbol moves the FSM to CHECK on the next edge. CHECK lasts 1 cycle.
- `unlock` / `alarm` are registered Moore outputs decoded from state.
  - Each is high from the edge after CHECK (or after the final symbol) for exactly OPEN_CYCLES / LOCK_CYCLES cycles.
- `fail_cnt` updates on the edge leaving CHECK, and clears on the edge leaving LOCKOUT.
- Reset asserted mid-ENTRY, mid-OPEN or mid-LOCKOUT aborts immediately: outputs drop asynchronously.
- `code_load` coinciding with an IDLE→ENTRY transition: both take effect. The new code applies to the attempt starting that cycle.

## Test plan
Bench parameters: CODE_LEN=4, DEFAULT_CODE=8'h0B, OPEN_CYCLES=5, LOCK_CYCLES=8, MAX_FAIL=3.
- Correct entry: press A,B,A,A, one press per 10 cycles → state 0→1→2→3; unlock high exactly 5 cycles; fail_cnt stays 0; then state=0.
- Three wrong codes (A,A,A,A three times) → fail_cnt 1, then 2, then state=4; alarm high exactly 8 cycles; fail_cnt=0 after. A, B presses during lockout change nothing.
- Reprogram: code_load=1 with code_in=8'h06 in IDLE, then enter B,A,A,B → unlock. The old code A,B,A,A now fails with fail_cnt=1. code_load during OPEN leaves code_reg unchanged.
- Simultaneous press: raise a and b on the same cycle → no state change and sym_cnt stays 0. A following A,B,A,A → unlock.
- Reset mid-operation: assert resetn=0 during ENTRY after 2 symbols, then during OPEN → state=0, unlock=0, fail_cnt=0 at once; code_reg returns to 8'h0B.
- Glitch/latency: a held high across 1 edge, then low → symbol registered 2 edges later. A held high 20 cycles → exactly one symbol.
